// File: rtl/video_pkg.sv
// Shared video constants, stage bundle and zoom-factor helpers for the
// framebuffer scanout path.
package video_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = 800;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = 525;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;

  localparam int FB_AW = 19;
  localparam int PIX_W = 8;
  localparam int CNT_W = 11;

  typedef struct packed {
    logic             in_img;
    logic             active;
    logic             hs;
    logic             vs;
    logic             fv;
    logic [PIX_W-1:0] hpix;
  } pix_ctl_t;

  localparam pix_ctl_t PIX_CTL_RST = '{
    in_img: 1'b0,
    active: 1'b0,
    hs:     1'b1,
    vs:     1'b1,
    fv:     1'b0,
    hpix:   '0
  };

  // Only 1..4 are meaningful zoom factors; anything else draws at 1x.
  function automatic logic [2:0] fator_sanitize(
    input logic [2:0] f
  );
    logic [2:0] r;
    r = 3'd1;
    unique case (1'b1)
      (f == 3'd1): r = 3'd1;
      (f == 3'd2): r = 3'd2;
      (f == 3'd3): r = 3'd3;
      (f == 3'd4): r = 3'd4;
      default:     r = 3'd1;
    endcase
    return r;
  endfunction

  // Shift-add scaling of an image dimension by a 3-bit factor.
  function automatic logic [CNT_W-1:0] scale_dim(
    input logic [CNT_W-1:0] base,
    input logic [2:0]       f
  );
    logic [CNT_W-1:0] acc;
    acc = '0;
    if (f[0]) acc = acc + base;
    if (f[1]) acc = acc + (base << 1);
    if (f[2]) acc = acc + (base << 2);
    return acc;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with sync, active-area and
// frame-start decode.
module vga_timing #(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_FP     = video_pkg::H_FP,
  parameter int H_SYNC   = video_pkg::H_SYNC,
  parameter int H_BP     = video_pkg::H_BP,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_FP     = video_pkg::V_FP,
  parameter int V_SYNC   = video_pkg::V_SYNC,
  parameter int V_BP     = video_pkg::V_BP
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        active,
  output logic        hs,
  output logic        vs,
  output logic        frame_start
);
  import video_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_B   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_E   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_B   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_E   = 11'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) v_cnt <= '0;
      else                 v_cnt <= v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs = !((h_cnt >= HS_B) && (h_cnt < HS_E));
  assign vs = !((v_cnt >= VS_B) && (v_cnt < VS_E));
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_framebuffer_scanout.sv
// Centred grayscale framebuffer scanout with VGA timing.
// Optional macro VGA_TEST_PATTERN_EN: gray ramp while no valid frame.
module vga_framebuffer_scanout #(
  parameter int IMG_W    = video_pkg::IMG_W,
  parameter int IMG_H    = video_pkg::IMG_H,
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_FP     = video_pkg::H_FP,
  parameter int H_SYNC   = video_pkg::H_SYNC,
  parameter int H_BP     = video_pkg::H_BP,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_FP     = video_pkg::V_FP,
  parameter int V_SYNC   = video_pkg::V_SYNC,
  parameter int V_BP     = video_pkg::V_BP
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    fator,
  input  logic                          frame_valid,
  output logic [video_pkg::FB_AW-1:0]   ram_rdaddr,
  input  logic [video_pkg::PIX_W-1:0]   ram_q,
  output logic [video_pkg::PIX_W-1:0]   vga_r,
  output logic [video_pkg::PIX_W-1:0]   vga_g,
  output logic [video_pkg::PIX_W-1:0]   vga_b,
  output logic                          vga_hs,
  output logic                          vga_vs,
  output logic                          vga_blank_n,
  output logic                          vga_sync_n
);
  import video_pkg::*;

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        active;
  logic        hs;
  logic        vs;
  logic        frame_start;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hs          (hs),
    .vs          (vs),
    .frame_start (frame_start)
  );

  logic [2:0] fator_q;
  logic       fv_q;
  logic [2:0] f_eff;
  logic       fv_eff;

  // The frame-start cycle already draws with the freshly latched settings.
  assign f_eff  = frame_start ? fator_sanitize(fator) : fator_q;
  assign fv_eff = frame_start ? frame_valid : fv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fator_q <= 3'd1;
      fv_q    <= 1'b0;
    end else if (frame_start) begin
      fator_q <= fator_sanitize(fator);
      fv_q    <= frame_valid;
    end
  end

  logic [10:0] img_w;
  logic [10:0] img_h;
  logic [10:0] ox;
  logic [10:0] oy;
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        in_img;
  logic        last_px;

  assign img_w = scale_dim(11'(IMG_W), f_eff);
  assign img_h = scale_dim(11'(IMG_H), f_eff);
  assign ox    = (11'(H_ACTIVE) - img_w) >> 1;
  assign oy    = (11'(V_ACTIVE) - img_h) >> 1;
  assign x_end = ox + img_w;
  assign y_end = oy + img_h;

  assign in_img = fv_eff
               && (h_cnt >= ox) && (h_cnt < x_end)
               && (v_cnt >= oy) && (v_cnt < y_end);

  assign last_px = (h_cnt == x_end - 11'd1)
                && (v_cnt == y_end - 11'd1);

  logic [FB_AW-1:0] addr;
  logic [FB_AW-1:0] cur_addr;

  assign cur_addr = frame_start ? '0 : addr;

  // Holding on the last pixel keeps the address within W*H-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (in_img && !last_px) begin
      addr <= cur_addr + 19'd1;
    end else begin
      addr <= cur_addr;
    end
  end

  pix_ctl_t s1;
  pix_ctl_t s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_rdaddr <= '0;
      s1         <= PIX_CTL_RST;
      s2         <= PIX_CTL_RST;
    end else begin
      ram_rdaddr <= cur_addr;
      s1.in_img  <= in_img;
      s1.active  <= active;
      s1.hs      <= hs;
      s1.vs      <= vs;
      s1.fv      <= fv_eff;
      s1.hpix    <= h_cnt[7:0];
      s2         <= s1;
    end
  end

  logic [PIX_W-1:0] pix;

  always_comb begin
    pix = '0;
    if (s2.active) begin
      if (s2.in_img) begin
        pix = ram_q;
      end
`ifdef VGA_TEST_PATTERN_EN
      else if (!s2.fv) begin
        pix = s2.hpix;
      end
`endif
    end
  end

`ifndef VGA_TEST_PATTERN_EN
  logic unused_pattern;
  assign unused_pattern = ^{s2.fv, s2.hpix};
`endif

  assign vga_r       = pix;
  assign vga_g       = pix;
  assign vga_b       = pix;
  assign vga_hs      = s2.hs;
  assign vga_vs      = s2.vs;
  assign vga_blank_n = s2.active;
  assign vga_sync_n  = 1'b0;

endmodule
